mem_arbiter: RTL and testbench

Shares one single-outstanding memory bus between the instruction fetch unit and the exec-stage load/store outputs (MEM_R_*/MEM_W_*). Data accesses have priority over fetch, with a starvation limit. The block stalls the pipeline while a data access is in flight. It returns load data aligned and sign/zero-extended for register writeback.

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_load_align.sv | 33 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM/owner encodings, the registered
// bus request and the saturating counter helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2,
        OWN_STORE = 2'd3
    } owner_e;

    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_req_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, exec load/store, pipeline stall and memory bus signals of the arbiter.
// slave is the arbiter's view; master is the surrounding core and bus.
interface mem_arbiter_if;
    logic        INST_REQ;
    logic [31:0] INST_ADDR;
    logic        INST_FLUSH;
    logic        INST_ACK;
    logic [31:0] INST_RDATA;
    logic        MEM_R_VALID;
    logic [4:0]  MEM_R_RD;
    logic [31:0] MEM_R_ADDR;
    logic [3:0]  MEM_R_STRB;
    logic        MEM_R_SIGNED;
    logic        MEM_W_VALID;
    logic [31:0] MEM_W_ADDR;
    logic [3:0]  MEM_W_STRB;
    logic [31:0] MEM_W_DATA;
    logic        STALL;
    logic        LOAD_VALID;
    logic [4:0]  LOAD_RD;
    logic [31:0] LOAD_DATA;
    logic        BUS_REQ_VALID;
    logic        BUS_REQ_READY;
    logic        BUS_REQ_WE;
    logic [31:0] BUS_REQ_ADDR;
    logic [3:0]  BUS_REQ_STRB;
    logic [31:0] BUS_REQ_WDATA;
    logic        BUS_RESP_VALID;
    logic [31:0] BUS_RESP_RDATA;

    modport slave (
        input  INST_REQ, INST_ADDR, INST_FLUSH,
        input  MEM_R_VALID, MEM_R_RD, MEM_R_ADDR, MEM_R_STRB, MEM_R_SIGNED,
        input  MEM_W_VALID, MEM_W_ADDR, MEM_W_STRB, MEM_W_DATA,
        input  BUS_REQ_READY, BUS_RESP_VALID, BUS_RESP_RDATA,
        output INST_ACK, INST_RDATA, STALL, LOAD_VALID, LOAD_RD, LOAD_DATA,
        output BUS_REQ_VALID, BUS_REQ_WE, BUS_REQ_ADDR, BUS_REQ_STRB, BUS_REQ_WDATA
    );

    modport master (
        output INST_REQ, INST_ADDR, INST_FLUSH,
        output MEM_R_VALID, MEM_R_RD, MEM_R_ADDR, MEM_R_STRB, MEM_R_SIGNED,
        output MEM_W_VALID, MEM_W_ADDR, MEM_W_STRB, MEM_W_DATA,
        output BUS_REQ_READY, BUS_RESP_VALID, BUS_RESP_RDATA,
        input  INST_ACK, INST_RDATA, STALL, LOAD_VALID, LOAD_RD, LOAD_DATA,
        input  BUS_REQ_VALID, BUS_REQ_WE, BUS_REQ_ADDR, BUS_REQ_STRB, BUS_REQ_WDATA
    );
endinterface

// File: rtl/mem_arbiter_load_align.sv
// Combinational load data extraction: lanes selected by strb are moved to
// bit 0 and extended to 32 bits for register writeback.
module load_align (
    input  logic [3:0]  strb,
    input  logic        is_signed,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    function automatic logic [1:0] low_lane(input logic [3:0] s);
        if (s[0])      return 2'd0;
        else if (s[1]) return 2'd1;
        else if (s[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [2:0] lane_count(input logic [3:0] s);
        return {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
    endfunction

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {low_lane(strb), 3'b000};
        data    = shifted;
        case (lane_count(strb))
            3'd1:    data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            3'd2:    data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory bus arbiter between instruction fetch and exec
// loads/stores, with data priority, fetch anti-starvation and pipeline stall.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned FETCH_STARVE_LIMIT = 4
) (
    input logic           CLK,
    input logic           RST_N,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_LIMIT = 4'(FETCH_STARVE_LIMIT);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    bus_req_t    req_q, req_d;
    logic [4:0]  rd_q, rd_d;
    logic        sgn_q, sgn_d;
    logic [3:0]  starve_q, starve_d;
    logic        flushed_q, flushed_d;
    logic        w_done_q, w_done_d;

    logic        resp_now, w_resp_now, r_resp_now, stall;
    logic        inst_ack, grant_fetch, grant_data;
    logic [31:0] aligned;

    assign resp_now   = (state_q == ST_WAIT) && bus.BUS_RESP_VALID;
    assign w_resp_now = resp_now && (owner_q == OWN_STORE);
    assign r_resp_now = resp_now && (owner_q == OWN_LOAD);
    assign inst_ack   = resp_now && (owner_q == OWN_FETCH) && !flushed_q;
    // Stall drops in the response cycle of the last outstanding data access.
    assign stall = (bus.MEM_W_VALID && !(w_done_q || w_resp_now)) ||
                   (bus.MEM_R_VALID && !r_resp_now);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            req_q     <= '0;
            rd_q      <= '0;
            sgn_q     <= 1'b0;
            starve_q  <= '0;
            flushed_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            req_q     <= req_d;
            rd_q      <= rd_d;
            sgn_q     <= sgn_d;
            starve_q  <= starve_d;
            flushed_q <= flushed_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_d       = req_q;
        rd_d        = rd_q;
        sgn_d       = sgn_q;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.INST_REQ && (starve_q == STARVE_LIMIT)) begin
                    grant_fetch = 1'b1;
                end else if (bus.MEM_W_VALID && !w_done_q) begin
                    grant_data = 1'b1;
                    owner_d    = OWN_STORE;
                    req_d      = '{1'b1, bus.MEM_W_ADDR, bus.MEM_W_STRB, bus.MEM_W_DATA};
                end else if (bus.MEM_R_VALID) begin
                    grant_data = 1'b1;
                    owner_d    = OWN_LOAD;
                    req_d      = '{1'b0, bus.MEM_R_ADDR, bus.MEM_R_STRB, 32'h0};
                    rd_d       = bus.MEM_R_RD;
                    sgn_d      = bus.MEM_R_SIGNED;
                end else if (bus.INST_REQ) begin
                    grant_fetch = 1'b1;
                end
                if (grant_fetch) begin
                    owner_d = OWN_FETCH;
                    req_d   = '{1'b0, bus.INST_ADDR, STRB_WORD, 32'h0};
                end
                if (grant_fetch || grant_data) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.BUS_REQ_READY) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.BUS_RESP_VALID) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.INST_REQ || grant_fetch) starve_d = '0;
        else if (grant_data)              starve_d = sat_inc4(starve_q);

        flushed_d = flushed_q;
        if (state_d == ST_IDLE)
            flushed_d = 1'b0;
        else if ((state_q != ST_IDLE) && (owner_q == OWN_FETCH) && bus.INST_FLUSH)
            flushed_d = 1'b1;

        // A completed store is remembered only while exec is still frozen.
        w_done_d = stall ? (w_done_q || w_resp_now) : 1'b0;
    end

    load_align u_align (
        .strb      (req_q.strb),
        .is_signed (sgn_q),
        .rdata     (bus.BUS_RESP_RDATA),
        .data      (aligned)
    );

    always_comb begin
        bus.BUS_REQ_VALID = (state_q == ST_REQ);
        bus.BUS_REQ_WE    = req_q.we;
        bus.BUS_REQ_ADDR  = req_q.addr;
        bus.BUS_REQ_STRB  = req_q.strb;
        bus.BUS_REQ_WDATA = req_q.wdata;
        bus.STALL         = stall;
        bus.INST_ACK      = inst_ack;
        bus.INST_RDATA    = inst_ack ? bus.BUS_RESP_RDATA : 32'h0;
        bus.LOAD_VALID    = r_resp_now;
        bus.LOAD_RD       = r_resp_now ? rd_q : 5'h0;
        bus.LOAD_DATA     = r_resp_now ? aligned : 32'h0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus queues expected bus
// requests and responses; a monitor pops and compares as the DUT presents them.
module tb_mem_arbiter;

    logic CLK = 1'b0;
    logic RST_N;
    mem_arbiter_if bus();

    mem_arbiter #(.FETCH_STARVE_LIMIT(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic        sgn;
    } ld_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [68:0] exp_req_q[$];
    logic [31:0] exp_inst_q[$];
    logic [36:0] exp_load_q[$];
    logic [31:0] bus_rdq[$];
    ld_t         ld_q[$];

    int ready_gap = 0;
    int resp_gap  = 0;
    int first_ack, n_ack, first_load, n_load;
    logic stall_at[0:63];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus model: READY after ready_gap REQ cycles, response resp_gap cycles into WAIT.
    initial begin
        int req_cyc;
        int resp_cnt;
        logic [31:0] cur_rd;
        req_cyc  = 0;
        resp_cnt = 0;
        cur_rd   = '0;
        bus.BUS_REQ_READY  = 1'b0;
        bus.BUS_RESP_VALID = 1'b0;
        bus.BUS_RESP_RDATA = '0;
        forever begin
            @(negedge CLK);
            bus.BUS_RESP_VALID = 1'b0;
            bus.BUS_RESP_RDATA = '0;
            if (!RST_N) begin
                resp_cnt = 0;
                req_cyc  = 0;
                bus.BUS_REQ_READY = 1'b0;
            end else begin
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        bus.BUS_RESP_VALID = 1'b1;
                        bus.BUS_RESP_RDATA = cur_rd;
                    end
                end
                if (bus.BUS_REQ_VALID) begin
                    if (req_cyc >= ready_gap) begin
                        bus.BUS_REQ_READY = 1'b1;
                        resp_cnt = resp_gap + 1;
                        cur_rd   = (bus_rdq.size() > 0) ? bus_rdq.pop_front() : 32'h0;
                        req_cyc  = 0;
                    end else begin
                        bus.BUS_REQ_READY = 1'b0;
                        req_cyc++;
                    end
                end else begin
                    bus.BUS_REQ_READY = 1'b0;
                    req_cyc = 0;
                end
            end
        end
    end

    // Monitor: compares every accepted bus request, fetch ack and load result.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (RST_N) begin
                if (bus.BUS_REQ_VALID && bus.BUS_REQ_READY) begin
                    if (exp_req_q.size() == 0) check("bus_req_unexpected", 1, 0);
                    else check("bus_req", {bus.BUS_REQ_WE, bus.BUS_REQ_ADDR, bus.BUS_REQ_STRB,
                                           bus.BUS_REQ_WDATA}, exp_req_q.pop_front());
                end
                if (bus.INST_ACK) begin
                    if (exp_inst_q.size() == 0) check("inst_ack_unexpected", 1, 0);
                    else check("inst_rdata", bus.INST_RDATA, exp_inst_q.pop_front());
                end
                if (bus.LOAD_VALID) begin
                    if (exp_load_q.size() == 0) check("load_unexpected", 1, 0);
                    else check("load_rd_data", {bus.LOAD_RD, bus.LOAD_DATA}, exp_load_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        #3;
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [31:0] rdata);
        exp_req_q.push_back({we, addr, strb, wdata});
        bus_rdq.push_back(rdata);
    endtask

    task automatic add_load(input logic [4:0] rd, input logic [31:0] addr, input logic [3:0] strb,
                            input logic sgn, input logic [31:0] expd);
        ld_t l;
        l.rd = rd; l.addr = addr; l.strb = strb; l.sgn = sgn;
        ld_q.push_back(l);
        exp_load_q.push_back({rd, expd});
    endtask

    task automatic start_load();
        ld_t l;
        l = ld_q.pop_front();
        bus.MEM_R_VALID  = 1'b1;
        bus.MEM_R_RD     = l.rd;
        bus.MEM_R_ADDR   = l.addr;
        bus.MEM_R_STRB   = l.strb;
        bus.MEM_R_SIGNED = l.sgn;
    endtask

    // Runs n cycles acting as fetch unit and exec stage; records event cycles.
    task automatic run(input int n);
        first_ack = -1; n_ack = 0; first_load = -1; n_load = 0;
        for (int c = 1; c <= n; c++) begin
            step();
            stall_at[c] = bus.STALL;
            if (bus.INST_ACK) begin
                n_ack++;
                if (first_ack < 0) first_ack = c;
                bus.INST_REQ = 1'b0;
            end
            if (bus.LOAD_VALID) begin
                n_load++;
                if (first_load < 0) first_load = c;
            end
            if (!bus.STALL) begin
                bus.MEM_W_VALID = 1'b0;
                if (bus.MEM_R_VALID && ld_q.size() > 0) start_load();
                else bus.MEM_R_VALID = 1'b0;
            end
        end
    endtask

    initial begin
        RST_N = 1'b0;
        bus.INST_REQ = 1'b0;    bus.INST_ADDR = '0;    bus.INST_FLUSH = 1'b0;
        bus.MEM_R_VALID = 1'b0; bus.MEM_R_RD = '0;     bus.MEM_R_ADDR = '0;
        bus.MEM_R_STRB = '0;    bus.MEM_R_SIGNED = 1'b0;
        bus.MEM_W_VALID = 1'b0; bus.MEM_W_ADDR = '0;   bus.MEM_W_STRB = '0;
        bus.MEM_W_DATA = '0;
        repeat (3) step();
        check("rst_bus_req_valid", bus.BUS_REQ_VALID, 0);
        check("rst_bus_req_fields", {bus.BUS_REQ_WE, bus.BUS_REQ_ADDR, bus.BUS_REQ_STRB, bus.BUS_REQ_WDATA}, 0);
        check("rst_stall", bus.STALL, 0);
        check("rst_inst", {bus.INST_ACK, bus.INST_RDATA}, 0);
        check("rst_load", {bus.LOAD_VALID, bus.LOAD_RD, bus.LOAD_DATA}, 0);
        RST_N = 1'b1;
        step();

        // Fetch only: READY in REQ, response one cycle into WAIT.
        ready_gap = 0; resp_gap = 1;
        exp_bus(1'b0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF);
        exp_inst_q.push_back(32'hDEADBEEF);
        bus.INST_REQ = 1'b1; bus.INST_ADDR = 32'h100;
        run(8);
        check("fetch_ack_cycle", first_ack, 3);
        check("fetch_stall", stall_at[1] | stall_at[2] | stall_at[3], 0);

        // lb signed from lane 2, then lhu from lanes 2-3.
        resp_gap = 0;
        exp_bus(1'b0, 32'h200, 4'b0100, 32'h0, 32'h0080_0000);
        add_load(5'd5, 32'h200, 4'b0100, 1'b1, 32'hFFFF_FF80);
        start_load();
        run(6);
        check("lb_load_cycle", first_load, 2);
        check("lb_stall_req", stall_at[1], 1);
        check("lb_stall_resp", stall_at[2], 0);
        exp_bus(1'b0, 32'h200, 4'b1100, 32'h0, 32'h8001_0000);
        add_load(5'd6, 32'h200, 4'b1100, 1'b0, 32'h0000_8001);
        start_load();
        run(6);
        check("lhu_load_cycle", first_load, 2);

        // Store and fetch together: store first, then fetch.
        exp_bus(1'b1, 32'h300, 4'b0011, 32'h0000_ABCD, 32'h0);
        exp_bus(1'b0, 32'h104, 4'hF, 32'h0, 32'h1122_3344);
        exp_inst_q.push_back(32'h1122_3344);
        bus.MEM_W_VALID = 1'b1; bus.MEM_W_ADDR = 32'h300;
        bus.MEM_W_STRB = 4'b0011; bus.MEM_W_DATA = 32'h0000_ABCD;
        bus.INST_REQ = 1'b1; bus.INST_ADDR = 32'h104;
        run(10);
        check("sf_stall_req", stall_at[1], 1);
        check("sf_stall_resp", stall_at[2], 0);
        check("sf_fetch_ack_cycle", first_ack, 5);

        // Starvation: four loads, one forced fetch, then loads resume.
        for (int i = 0; i < 6; i++) begin
            add_load(5'(i + 1), 32'h500 + 32'(4 * i), 4'hF, 1'b0, 32'h1000 + 32'(i));
            if (i == 4) exp_bus(1'b0, 32'h400, 4'hF, 32'h0, 32'hF00D_F00D);
            exp_bus(1'b0, 32'h500 + 32'(4 * i), 4'hF, 32'h0, 32'h1000 + 32'(i));
        end
        exp_inst_q.push_back(32'hF00D_F00D);
        bus.INST_REQ = 1'b1; bus.INST_ADDR = 32'h400;
        start_load();
        run(30);
        check("starve_loads", n_load, 6);
        check("starve_acks", n_ack, 1);
        check("starve_fetch_cycle", first_ack, 14);

        // Flush during WAIT: response swallowed, then a clean fetch follows.
        resp_gap = 2;
        exp_bus(1'b0, 32'h600, 4'hF, 32'h0, 32'hBAD0_BAD0);
        bus.INST_REQ = 1'b1; bus.INST_ADDR = 32'h600;
        step();
        step();
        bus.INST_FLUSH = 1'b1; bus.INST_REQ = 1'b0;
        step();
        bus.INST_FLUSH = 1'b0;
        run(6);
        check("flush_no_ack", n_ack, 0);
        check("flush_idle", bus.BUS_REQ_VALID, 0);
        resp_gap = 0;
        exp_bus(1'b0, 32'h604, 4'hF, 32'h0, 32'h1234_5678);
        exp_inst_q.push_back(32'h1234_5678);
        bus.INST_REQ = 1'b1; bus.INST_ADDR = 32'h604;
        run(6);
        check("post_flush_ack_cycle", first_ack, 2);

        // Asynchronous reset while the bus holds off READY.
        ready_gap = 100;
        bus.INST_REQ = 1'b1; bus.INST_ADDR = 32'h700;
        step();
        check("rstreq_valid", {bus.BUS_REQ_VALID, bus.BUS_REQ_ADDR}, {1'b1, 32'h700});
        step();
        RST_N = 1'b0; bus.INST_REQ = 1'b0;
        #1;
        check("rstreq_bus_cleared", {bus.BUS_REQ_VALID, bus.BUS_REQ_ADDR, bus.BUS_REQ_STRB}, 0);
        check("rstreq_outputs", {bus.STALL, bus.INST_ACK, bus.LOAD_VALID}, 0);
        step();
        step();
        ready_gap = 0;
        RST_N = 1'b1;
        exp_bus(1'b0, 32'h704, 4'hF, 32'h0, 32'hCAFE_F00D);
        exp_inst_q.push_back(32'hCAFE_F00D);
        bus.INST_REQ = 1'b1; bus.INST_ADDR = 32'h704;
        run(6);
        check("post_reset_ack_cycle", first_ack, 2);

        step();
        check("req_queue_drained", exp_req_q.size(), 0);
        check("inst_queue_drained", exp_inst_q.size(), 0);
        check("load_queue_drained", exp_load_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
